// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: source count, FSM states
// and register map.
package irq_pkg;

    localparam int N_SRC = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_MASK      = 2'd0;
    localparam logic [1:0] ADDR_PENDING   = 2'd1;
    localparam logic [1:0] ADDR_INSERVICE = 2'd2;
    localparam logic [1:0] ADDR_RSVD      = 2'd3;

endpackage

// File: rtl/irq_sync.sv
// Per-source synchronizer chain plus a one-flop rising-edge detector.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    // Edge flop resets low, so a line held high through reset yields one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: fixed priority, single in-service
// interrupt, MASK / PENDING (W1C) / INSERVICE register access.
module irq_controller #(
    parameter int N_SRC       = irq_pkg::N_SRC,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             reg_we,
    input  logic [1:0]       reg_addr,
    input  logic [N_SRC-1:0] reg_wd,
    output logic [N_SRC-1:0] reg_rd,
    input  logic             irq_ack,
    input  logic             irq_eoi,
    output logic [2:0]       IRQ
);

    import irq_pkg::*;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] insvc_q;
    logic [N_SRC-1:0] elig, win_oh, clr;
    logic [2:0]       win_q, win_idx, irq_q;
    logic             any_elig, ack_ok, eoi_ok, win_live;
    logic             wr_mask, wr_pend;
    state_e           state_q;

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst    (rst),
            .src_i  (irq_src[g]),
            .rise_o (rise[g])
        );
    end

    assign elig = pend_q & mask_q;

    // Ascending scan: the last hit is the highest index, i.e. the winner.
    always_comb begin
        any_elig = 1'b0;
        win_idx  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (elig[i]) begin
                any_elig = 1'b1;
                win_idx  = 3'(i);
            end
        end
    end

    always_comb begin
        win_oh         = '0;
        win_oh[win_q]  = 1'b1;
    end

    assign ack_ok  = (state_q == REQUEST) && irq_ack;
    assign eoi_ok  = (state_q == SERVICE) && irq_eoi;
    assign wr_mask = reg_we && (reg_addr == ADDR_MASK);
    assign wr_pend = reg_we && (reg_addr == ADDR_PENDING);

    // A fresh edge overrides a same-cycle clear (ack or W1C).
    assign mask_d   = wr_mask ? reg_wd : mask_q;
    assign clr      = (wr_pend ? reg_wd : '0) | (ack_ok ? win_oh : '0);
    assign pend_d   = (pend_q & ~clr) | rise;
    assign win_live = |(mask_d & pend_d & win_oh);

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            pend_q <= '0;
        end else begin
            mask_q <= mask_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            irq_q   <= '0;
            win_q   <= '0;
            insvc_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_elig) begin
                        win_q   <= win_idx;
                        irq_q   <= win_idx + 3'd1;
                        state_q <= REQUEST;
                    end else begin
                        irq_q   <= '0;
                    end
                end
                REQUEST: begin
                    if (ack_ok) begin
                        insvc_q <= win_oh;
                        irq_q   <= '0;
                        state_q <= SERVICE;
                    end else if (!win_live) begin
                        irq_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                SERVICE: begin
                    irq_q <= '0;
                    if (eoi_ok) begin
                        insvc_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    irq_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        reg_rd = '0;
        case (reg_addr)
            ADDR_MASK:      reg_rd = mask_q;
            ADDR_PENDING:   reg_rd = pend_q;
            ADDR_INSERVICE: reg_rd = insvc_q;
            default:        reg_rd = '0;
        endcase
    end

    assign IRQ = irq_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed vector table, corner-case sequences and
// randomized traffic against a cycle-level reference model.
module tb_irq_controller;

    localparam int NS = 7;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] irq_src, reg_wd, reg_rd;
    logic          reg_we, irq_ack, irq_eoi;
    logic [1:0]    reg_addr;
    logic [2:0]    IRQ;

    int n_cmp = 0;
    int n_bad = 0;

    irq_controller #(.N_SRC(NS), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_src  (irq_src),
        .reg_we   (reg_we),
        .reg_addr (reg_addr),
        .reg_wd   (reg_wd),
        .reg_rd   (reg_rd),
        .irq_ack  (irq_ack),
        .irq_eoi  (irq_eoi),
        .IRQ      (IRQ)
    );

    always #5 clk = ~clk;

    // Reference model: history of sampled lines, register images, mode 0/1/2.
    logic [NS-1:0] m_mask, m_pend, m_insvc;
    logic [NS-1:0] m_hist[$];
    int            m_mode, m_win, m_irq;

    task automatic model_reset();
        m_mask = '0; m_pend = '0; m_insvc = '0;
        m_mode = 0; m_win = 0; m_irq = 0;
        m_hist = {};
        for (int i = 0; i <= SS; i++) m_hist.push_back('0);
    endtask

    task automatic model_step();
        logic [NS-1:0] rise, clr, mask_n, pend_n, elig;
        if (rst) begin
            model_reset();
            return;
        end
        rise = m_hist[SS-1] & ~m_hist[SS];
        m_hist.push_front(irq_src);
        void'(m_hist.pop_back());
        mask_n = (reg_we && reg_addr == 2'd0) ? reg_wd : m_mask;
        clr    = (reg_we && reg_addr == 2'd1) ? reg_wd : '0;
        if (m_mode == 1 && irq_ack) clr[m_win] = 1'b1;
        pend_n = (m_pend & ~clr) | rise;
        case (m_mode)
            0: begin
                elig = m_pend & m_mask;
                m_irq = 0;
                for (int i = NS - 1; i >= 0; i--) begin
                    if (elig[i]) begin
                        m_win = i; m_irq = i + 1; m_mode = 1;
                        break;
                    end
                end
            end
            1: begin
                if (irq_ack) begin
                    m_insvc = '0; m_insvc[m_win] = 1'b1;
                    m_irq = 0; m_mode = 2;
                end else if (!(mask_n[m_win] && pend_n[m_win])) begin
                    m_irq = 0; m_mode = 0;
                end
            end
            default: begin
                m_irq = 0;
                if (irq_eoi) begin m_insvc = '0; m_mode = 0; end
            end
        endcase
        m_mask = mask_n;
        m_pend = pend_n;
    endtask

    function automatic logic [NS-1:0] model_rd(logic [1:0] a);
        case (a)
            2'd0:    return m_mask;
            2'd1:    return m_pend;
            2'd2:    return m_insvc;
            default: return '0;
        endcase
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drv(logic [NS-1:0] s, logic we, logic [1:0] a, logic [NS-1:0] wd,
                       logic ack, logic eoi);
        irq_src = s; reg_we = we; reg_addr = a; reg_wd = wd;
        irq_ack = ack; irq_eoi = eoi;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv('0, 0, 2'd0, '0, 0, 0);
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [NS-1:0] src;
        logic          we;
        logic [1:0]    addr;
        logic [NS-1:0] wd;
        logic          ack, eoi;
        logic [2:0]    irq;
        logic [NS-1:0] rd;
    } vec_t;

    vec_t tv[$];

    task automatic add(logic [NS-1:0] s, logic we, logic [1:0] a, logic [NS-1:0] wd,
                       logic ack, logic eoi, logic [2:0] irq, logic [NS-1:0] rd);
        vec_t v;
        v.src = s; v.we = we; v.addr = a; v.wd = wd;
        v.ack = ack; v.eoi = eoi; v.irq = irq; v.rd = rd;
        tv.push_back(v);
    endtask

    initial begin
        int sets, first;
        rst = 1'b1;
        drv('0, 0, 2'd0, '0, 0, 0);
        model_reset();
        @(negedge clk);
        do_reset();

        chk("reset_irq", {5'd0, IRQ}, 8'd0);
        for (int a = 0; a < 3; a++) begin
            reg_addr = 2'(a); #1;
            chk("reset_reg", {1'b0, reg_rd}, 8'd0);
        end

        // single source, latency and ack/eoi handshake
        add(7'h00, 1, 2'd0, 7'h7F, 0, 0, 0, 7'h7F);
        add(7'h04, 0, 2'd1, 7'h00, 0, 0, 0, 7'h00);
        add(7'h04, 0, 2'd1, 7'h00, 0, 0, 0, 7'h00);
        add(7'h04, 0, 2'd1, 7'h00, 0, 0, 0, 7'h04);
        add(7'h04, 0, 2'd1, 7'h00, 0, 0, 3, 7'h04);
        add(7'h04, 0, 2'd2, 7'h00, 1, 0, 0, 7'h04);
        add(7'h04, 0, 2'd1, 7'h00, 0, 0, 0, 7'h00);
        add(7'h04, 0, 2'd2, 7'h00, 0, 1, 0, 7'h00);
        add(7'h00, 0, 2'd2, 7'h00, 0, 0, 0, 7'h00);
        add(7'h00, 0, 2'd0, 7'h00, 0, 0, 0, 7'h7F);
        add(7'h00, 0, 2'd1, 7'h00, 0, 0, 0, 7'h00);
        // two simultaneous sources, priority then the loser after eoi
        add(7'h22, 0, 2'd1, 7'h00, 0, 0, 0, 7'h00);
        add(7'h22, 0, 2'd1, 7'h00, 0, 0, 0, 7'h00);
        add(7'h22, 0, 2'd1, 7'h00, 0, 0, 0, 7'h22);
        add(7'h22, 0, 2'd1, 7'h00, 0, 0, 6, 7'h22);
        add(7'h22, 0, 2'd2, 7'h00, 1, 0, 0, 7'h20);
        add(7'h22, 0, 2'd1, 7'h00, 0, 0, 0, 7'h02);
        add(7'h22, 0, 2'd2, 7'h00, 0, 1, 0, 7'h00);
        add(7'h22, 0, 2'd1, 7'h00, 0, 0, 2, 7'h02);
        add(7'h22, 0, 2'd2, 7'h00, 1, 0, 0, 7'h02);
        add(7'h22, 0, 2'd2, 7'h00, 0, 1, 0, 7'h00);
        // INSERVICE is read-only, address 3 reads zero
        add(7'h00, 1, 2'd2, 7'h7F, 0, 0, 0, 7'h00);
        add(7'h00, 0, 2'd3, 7'h00, 0, 0, 0, 7'h00);

        for (int i = 0; i < tv.size(); i++) begin
            drv(tv[i].src, tv[i].we, tv[i].addr, tv[i].wd, tv[i].ack, tv[i].eoi);
            cycle();
            chk($sformatf("vec%0d_irq", i), {5'd0, IRQ}, {5'd0, tv[i].irq});
            chk($sformatf("vec%0d_rd", i), {1'b0, reg_rd}, {1'b0, tv[i].rd});
        end

        // masked source latches pending; enabling the mask raises it
        do_reset();
        drv(7'h10, 0, 2'd1, '0, 0, 0);
        repeat (3) cycle();
        chk("masked_pend", {1'b0, reg_rd}, 8'h10);
        cycle();
        chk("masked_irq", {5'd0, IRQ}, 8'd0);
        drv(7'h10, 1, 2'd0, 7'h10, 0, 0);
        cycle();
        chk("unmask_irq0", {5'd0, IRQ}, 8'd0);
        drv(7'h10, 0, 2'd0, '0, 0, 0);
        cycle();
        chk("unmask_irq", {5'd0, IRQ}, 8'd5);

        // higher source arriving in REQUEST does not preempt
        do_reset();
        drv(7'h00, 1, 2'd0, 7'h7F, 0, 0);
        cycle();
        drv(7'h04, 0, 2'd1, '0, 0, 0);
        repeat (4) cycle();
        chk("req_irq3", {5'd0, IRQ}, 8'd3);
        drv(7'h44, 0, 2'd1, '0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("req_hold", {5'd0, IRQ}, 8'd3);
        end
        chk("req_pend", {1'b0, reg_rd}, 8'h44);
        drv(7'h44, 0, 2'd2, '0, 1, 0);
        cycle();
        chk("req_ack", {5'd0, IRQ}, 8'd0);
        drv(7'h44, 0, 2'd2, '0, 0, 1);
        cycle();
        chk("req_eoi", {5'd0, IRQ}, 8'd0);
        drv(7'h44, 0, 2'd2, '0, 0, 0);
        cycle();
        chk("req_next", {5'd0, IRQ}, 8'd7);

        // same-cycle edge and W1C: set wins
        do_reset();
        drv(7'h08, 0, 2'd1, '0, 0, 0);
        repeat (2) cycle();
        drv(7'h08, 1, 2'd1, 7'h08, 0, 0);
        cycle();
        chk("setwins", {1'b0, reg_rd}, 8'h08);
        cycle();
        chk("w1c_clear", {1'b0, reg_rd}, 8'h00);

        // reset during SERVICE with a line held high
        do_reset();
        drv(7'h00, 1, 2'd0, 7'h7F, 0, 0);
        cycle();
        drv(7'h01, 0, 2'd1, '0, 0, 0);
        repeat (4) cycle();
        chk("svc_irq1", {5'd0, IRQ}, 8'd1);
        drv(7'h01, 0, 2'd2, '0, 1, 0);
        cycle();
        chk("svc_insvc", {1'b0, reg_rd}, 8'h01);
        rst = 1'b1;
        drv(7'h01, 0, 2'd0, '0, 0, 0);
        cycle();
        chk("rst_svc_irq", {5'd0, IRQ}, 8'd0);
        for (int a = 0; a < 3; a++) begin
            reg_addr = 2'(a); #1;
            chk("rst_svc_reg", {1'b0, reg_rd}, 8'd0);
        end
        cycle();
        rst = 1'b0;
        sets = 0; first = -1;
        drv(7'h01, 1, 2'd1, 7'h01, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (reg_rd[0]) begin
                sets++;
                if (first < 0) first = i;
            end
        end
        chk("post_rst_sets", 8'(sets), 8'd1);
        chk("post_rst_edge", 8'(first), 8'd3);

        // randomized traffic against the model
        drv('0, 0, 2'd0, '0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            logic [NS-1:0] s;
            s = irq_src;
            for (int b = 0; b < NS; b++)
                if ($urandom_range(7) == 0) s[b] = ~s[b];
            rst = ($urandom_range(199) == 0);
            drv(s, $urandom_range(3) == 0, 2'($urandom_range(3)), 7'($urandom),
                $urandom_range(2) == 0, $urandom_range(2) == 0);
            if (i < 20) reg_we = (i == 0);
            if (i == 0) begin reg_addr = 2'd0; reg_wd = 7'h7F; end
            cycle();
            chk("rand_irq", {5'd0, IRQ}, 8'(m_irq));
            chk("rand_rd", {1'b0, reg_rd}, {1'b0, model_rd(reg_addr)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
